gate_truth_table_sequencer: RTL and testbench
=============================================

// Module: gate_truth_table_sequencer
// PURPOSE
//  Clocked stimulus/check stage that sits directly upstream of a combinational basic gate, e.g. two_input_or.
//  Drives every input vector 0..2**N_IN-1 onto the gate in ascending order.
//  Holds each vector for HOLD_CYCLES cycles, then samples the gate's answer and compares it with the expected truth table.
//  Reports pass/fail, the error count and the first failing vector. Replaces hand-written per-gate stimulus blocks.
// PARAMETERS
//  N_IN         2        gate input count; 1..4
//  HOLD_CYCLES  4        cycles each vector is held; >=1; answer is sampled in the last hold cycle
//  EXPECT       4'b1110  expected truth table, width 2**N_IN; bit i = required answer for in_vec==i (default = OR)
// PORTS
//  clk             in   1        rising-edge clock
//  reset           in   1        synchronous, active-high
//  start           in   1        begin a run; sampled only in IDLE or DONE
//  in_vec          out  N_IN     drives the gate inputs; bit0 -> in_a, bit1 -> in_b
//  answer          in   1        gate output under test
//  busy            out  1        high while vectors are being driven
//  done            out  1        high from end of run until next start or reset
//  pass            out  1        valid when done=1; 1 iff err_count==0
//  err_count       out  N_IN+1   number of mismatching vectors in this run
//  first_fail_idx  out  N_IN     index of the first mismatch; 0 if none
//  sample_valid    out  1        1-cycle pulse when answer is captured
//  sample_idx      out  N_IN     vector index of the capture; valid with sample_valid
// BEHAVIOUR
//  Reset: state=IDLE; every output =0 (in_vec=0, busy=0, done=0, pass=0, err_count=0, first_fail_idx=0, sample_valid=0).
//  States:
//  - IDLE: start=1 -> DRIVE; idx=0; hold_cnt=0; err_count, first_fail_idx and pass cleared.
//  - DRIVE: in_vec=idx; busy=1; hold_cnt increments each cycle.
//    - When hold_cnt==HOLD_CYCLES-1 in a cycle: capture answer at the end of that cycle.
//    - In that capture cycle: sample_valid=1 and sample_idx=idx.
//    - Mismatch (answer != EXPECT[idx]): err_count++; if it is the first mismatch, first_fail_idx=idx.
//    - After the capture: if idx==2**N_IN-1 go to DONE, else idx++ and hold_cnt=0.
//  - DONE: busy=0; done=1; pass=(err_count==0); in_vec returns to 0.
//    start=1 -> restart exactly as from IDLE.
//  Timing: start sampled high in cycle t -> vector 0 appears in cycle t+1.
//    Vector k is driven in cycles t+1+k*H .. t+(k+1)*H, with H = HOLD_CYCLES.
//    done=1 from cycle t+1+(2**N_IN)*H; with defaults, t+17.
//  start while busy: ignored; no restart and no counter change.
//  HOLD_CYCLES=1: a new vector every cycle, sample_valid high continuously while busy.
//  answer of X or Z: counts as a mismatch (use case-inequality !==).
//  reset mid-run: the reset takes priority over all other events in that cycle.
//    The next cycle is IDLE with all outputs 0. No partial results are retained.
//  err_count cannot overflow: it is N_IN+1 bits wide and holds the maximum of 2**N_IN.
// STRUCTURE
//  Shared include gate_test_defs.vh holds:
//  - state localparams ST_IDLE=2'd0, ST_DRIVE=2'd1, ST_DONE=2'd2;
//  - the truth-table constants TT_OR=4'b1110, TT_AND=4'b1000, TT_NAND=4'b0111, TT_NOR=4'b0001, TT_XOR=4'b0110.
//  One sub-module: gate_hold_timer.
//  - Parameter HOLD_CYCLES; ports clk, reset, clear, expire.
//  - expire goes high in the last hold cycle.
//  The FSM, the vector index and the scoreboard stay in the top level.
// TESTING
//  1. Defaults feeding two_input_or; start pulse at t.
//     -> in_vec steps 0,1,2,3 every 4 cycles; done at t+17; pass=1; err_count=0.
//  2. answer tied to 0, EXPECT=TT_OR.
//     -> err_count=3; first_fail_idx=1; pass=0; four sample_valid pulses with idx 0..3.
//  3. reset pulsed while in_vec==2.
//     -> next cycle IDLE with all outputs 0; a fresh start then completes with pass=1.
//  4. start re-pulsed during DRIVE -> ignored, done still at t+17.
//     start pulsed in DONE -> run restarts; counters cleared first.
//  5. HOLD_CYCLES=1, EXPECT=TT_NAND, a NAND-gate DUT.
//     -> sample_valid high for 4 consecutive cycles; done at t+5; pass=1.
//  6. N_IN=3, EXPECT=8'hFE, answer = OR of 3 bits.
//     -> 8 vectors; pass=1. Forcing answer=1'bx at idx 5 -> err_count=1, first_fail_idx=5.

Source files
------------

// File: rtl/gate_truth_table_sequencer_pkg.sv
// Shared types and constants for the gate truth-table sequencer: FSM state
// encoding, reference truth tables for the basic two-input gates, sizing helper.
package gate_truth_table_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } seq_state_t;

  // Bit i is the required gate answer when the gate inputs equal i.
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gate_hold_timer.sv
// Counts the cycles a vector has been held; expire marks the last hold cycle,
// after which the count wraps to zero for the next vector.
module gate_hold_timer
  import gate_truth_table_sequencer_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic expire
);

  localparam int CW = cnt_width(HOLD_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  // NOTE: reset is synchronous, so it is just the highest-priority branch of the
  // clocked block; all state updates here use non-blocking assignments.
  always_ff @(posedge clk) begin
    if (reset || clear || expire) cnt_q <= '0;
    else                          cnt_q <= cnt_q + 1'b1;
  end

  assign expire = (cnt_q == LAST);

endmodule

// File: rtl/gate_truth_table_sequencer.sv
// Walks every input vector of a combinational gate in ascending order, holds each
// for HOLD_CYCLES, samples the answer in the last hold cycle and scores it against EXPECT.
module gate_truth_table_sequencer
  import gate_truth_table_sequencer_pkg::*;
#(
  parameter int                    N_IN        = 2,
  parameter int                    HOLD_CYCLES = 4,
  parameter logic [2**N_IN-1:0]    EXPECT      = TT_OR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [N_IN-1:0] in_vec,
  input  logic            answer,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail_idx,
  output logic            sample_valid,
  output logic [N_IN-1:0] sample_idx
);

  localparam logic [N_IN-1:0] LAST_IDX = '1;

  seq_state_t      state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [N_IN-1:0] first_fail_q, first_fail_d;
  logic [N_IN:0]   err_q, err_d;
  logic            timer_clear;
  logic            expire;
  logic            mismatch;

  gate_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .clk   (clk),
    .reset (reset),
    .clear (timer_clear),
    .expire(expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      err_q        <= '0;
      first_fail_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      err_q        <= err_d;
      first_fail_q <= first_fail_d;
    end
  end

  // X or Z on the gate output must score as a failure, hence case-inequality.
  assign mismatch = (answer !== EXPECT[idx_q]);

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    err_d        = err_q;
    first_fail_d = first_fail_q;
    timer_clear  = 1'b1;
    in_vec       = '0;
    busy         = 1'b0;
    done         = 1'b0;
    sample_valid = 1'b0;
    sample_idx   = '0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        done = (state_q == ST_DONE);
        if (start) begin
          state_d      = ST_DRIVE;
          idx_d        = '0;
          err_d        = '0;
          first_fail_d = '0;
        end
      end

      ST_DRIVE: begin
        timer_clear = 1'b0;
        in_vec      = idx_q;
        busy        = 1'b1;
        if (expire) begin
          sample_valid = 1'b1;
          sample_idx   = idx_q;
          if (mismatch) begin
            err_d = err_q + 1'b1;
            if (err_q == '0) first_fail_d = idx_q;
          end
          if (idx_q == LAST_IDX) state_d = ST_DONE;
          else                   idx_d   = idx_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign pass           = (state_q == ST_DONE) && (err_q == '0);
  assign err_count      = err_q;
  assign first_fail_idx = first_fail_q;

endmodule

// File: tb/tb_gate_truth_table_sequencer.sv
// Bench for gate_truth_table_sequencer: three configurations checked every cycle
// against a timeline model, plus literal expectations for the directed scenarios.
module tb_gate_truth_table_sequencer;
  import gate_truth_table_sequencer_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset  = 1'b1;
  logic        start  = 1'b0;
  int          inst   = 0;
  logic [15:0] flip   = '0;
  logic        stuck0 = 1'b0;
  logic        x_en   = 1'b0;
  logic [3:0]  x_idx  = '0;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;
  bit chk_en = 1'b0;

  // Configuration A: defaults, two-input OR gate
  logic       start_a, ans_a, busy_a, done_a, pass_a, sv_a;
  logic [1:0] vec_a, ff_a, sidx_a;
  logic [2:0] err_a;
  assign start_a = start && (inst == 0);
  gate_truth_table_sequencer #(.N_IN(2), .HOLD_CYCLES(4), .EXPECT(TT_OR)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .in_vec(vec_a), .answer(ans_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .first_fail_idx(ff_a), .sample_valid(sv_a), .sample_idx(sidx_a));

  // Configuration B: single-cycle hold, NAND gate
  logic       start_b, ans_b, busy_b, done_b, pass_b, sv_b;
  logic [1:0] vec_b, ff_b, sidx_b;
  logic [2:0] err_b;
  assign start_b = start && (inst == 1);
  gate_truth_table_sequencer #(.N_IN(2), .HOLD_CYCLES(1), .EXPECT(TT_NAND)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .in_vec(vec_b), .answer(ans_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .first_fail_idx(ff_b), .sample_valid(sv_b), .sample_idx(sidx_b));

  // Configuration C: three-input OR gate
  logic       start_c, ans_c, busy_c, done_c, pass_c, sv_c;
  logic [2:0] vec_c, ff_c, sidx_c;
  logic [3:0] err_c;
  assign start_c = start && (inst == 2);
  gate_truth_table_sequencer #(.N_IN(3), .HOLD_CYCLES(4), .EXPECT(8'hFE)) dut_c (
    .clk(clk), .reset(reset), .start(start_c), .in_vec(vec_c), .answer(ans_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(err_c),
    .first_fail_idx(ff_c), .sample_valid(sv_c), .sample_idx(sidx_c));

  // Gate models with fault injection (flip inverts the answer for a vector)
  always_comb begin
    ans_a = (vec_a != 2'd0) ^ flip[vec_a];
    if (stuck0) ans_a = 1'b0;
    if (x_en && {2'b00, vec_a} == x_idx) ans_a = 1'bx;
  end

  always_comb begin
    ans_b = (vec_b != 2'd3) ^ flip[vec_b];
    if (stuck0) ans_b = 1'b0;
  end

  always_comb begin
    ans_c = (vec_c != 3'd0) ^ flip[vec_c];
    if (stuck0) ans_c = 1'b0;
    if (x_en && {1'b0, vec_c} == x_idx) ans_c = 1'bx;
  end

  // Outputs of the configuration under test
  logic [31:0] o_vec, o_ff, o_sidx, o_err;
  logic        o_busy, o_done, o_pass, o_sv, o_ans;
  always_comb begin
    o_vec = '0; o_ff = '0; o_sidx = '0; o_err = '0;
    o_busy = 1'b0; o_done = 1'b0; o_pass = 1'b0; o_sv = 1'b0; o_ans = 1'b0;
    case (inst)
      0: begin
        o_vec = 32'(vec_a); o_ff = 32'(ff_a); o_sidx = 32'(sidx_a); o_err = 32'(err_a);
        o_busy = busy_a; o_done = done_a; o_pass = pass_a; o_sv = sv_a; o_ans = ans_a;
      end
      1: begin
        o_vec = 32'(vec_b); o_ff = 32'(ff_b); o_sidx = 32'(sidx_b); o_err = 32'(err_b);
        o_busy = busy_b; o_done = done_b; o_pass = pass_b; o_sv = sv_b; o_ans = ans_b;
      end
      default: begin
        o_vec = 32'(vec_c); o_ff = 32'(ff_c); o_sidx = 32'(sidx_c); o_err = 32'(err_c);
        o_busy = busy_c; o_done = done_c; o_pass = pass_c; o_sv = sv_c; o_ans = ans_c;
      end
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc_n);
    end
  endtask

  // Timeline model: a run occupies n_vec()*n_hold() cycles after start; vector
  // k is held for n_hold() cycles and scored against the gate's logical rule.
  typedef enum int { P_IDLE, P_RUN, P_DONE } phase_t;
  phase_t      m_phase = P_IDLE;
  int          m_cyc   = 0;
  logic [15:0] mis     = '0;
  logic        ans_s   = 1'b0;

  function automatic int n_vec();
    return (inst == 2) ? 8 : 4;
  endfunction

  function automatic int n_hold();
    return (inst == 1) ? 1 : 4;
  endfunction

  function automatic logic exp_bit(input int j);
    if (inst == 1) return (j != 3);
    return (j != 0);
  endfunction

  always @(posedge clk) begin
    cyc_n++;
    if (reset) begin
      m_phase = P_IDLE;
      mis     = '0;
    end else if (m_phase == P_RUN) begin
      if (m_cyc % n_hold() == n_hold() - 1)
        mis[m_cyc / n_hold()] = (ans_s !== exp_bit(m_cyc / n_hold()));
      if (m_cyc == n_vec() * n_hold() - 1) m_phase = P_DONE;
      else                                 m_cyc++;
    end else if (start) begin
      m_phase = P_RUN;
      m_cyc   = 0;
      mis     = '0;
    end
  end

  int e_err, e_ff, e_h;
  bit e_run, e_sv;
  always @(negedge clk) begin
    if (chk_en) begin
      e_h   = n_hold();
      e_run = (m_phase == P_RUN);
      e_sv  = e_run && (m_cyc % e_h == e_h - 1);
      e_err = $countones(mis);
      e_ff  = 0;
      for (int j = 15; j >= 0; j--) if (mis[j]) e_ff = j;
      check("in_vec", o_vec, e_run ? 32'(m_cyc / e_h) : 32'd0);
      check("busy", 32'(o_busy), 32'(e_run));
      check("done", 32'(o_done), 32'(m_phase == P_DONE));
      check("pass", 32'(o_pass), 32'(m_phase == P_DONE && e_err == 0));
      check("err_count", o_err, 32'(e_err));
      check("first_fail_idx", o_ff, 32'(e_ff));
      check("sample_valid", 32'(o_sv), 32'(e_sv));
      if (e_sv) check("sample_idx", o_sidx, 32'(m_cyc / e_h));
    end
    ans_s = o_ans;
  end

  // One run: start pulse, then wait (bounded) for done while collecting timing.
  task automatic run(output int lat, output int nsv, output int isum,
                     output int mrun, input bit rand_restart);
    int t0, cur;
    bit seen;
    @(negedge clk);
    #1 start = 1'b1;
    t0 = cyc_n;
    lat = -1; nsv = 0; isum = 0; mrun = 0; cur = 0; seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (o_sv) begin
        nsv++;
        isum += int'(o_sidx);
        cur++;
        if (cur > mrun) mrun = cur;
      end else begin
        cur = 0;
      end
      if (o_done) begin
        seen = 1'b1;
        lat  = cyc_n - t0;
      end
      #1 start = rand_restart && o_busy && ($urandom_range(0, 1) == 1);
    end
    start = 1'b0;
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic switch_inst(input int k);
    @(negedge clk);
    #1 reset = 1'b1;
    inst = k;
    @(negedge clk);
    #1 reset = 1'b0;
  endtask

  int lat, nsv, isum, mrun, lowest;
  logic [3:0] fm;

  initial begin
    @(posedge clk);
    #1 chk_en = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(o_busy), 32'd0);
    check("reset_in_vec", o_vec, 32'd0);
    #1 reset = 1'b0;

    // Default OR gate, clean run
    run(lat, nsv, isum, mrun, 1'b0);
    check("t1_latency", 32'(lat), 32'd17);
    check("t1_err", o_err, 32'd0);
    check("t1_pass", 32'(o_pass), 32'd1);
    check("t1_samples", 32'(nsv), 32'd4);
    check("t1_idx_sum", 32'(isum), 32'd6);

    // Answer tied low
    stuck0 = 1'b1;
    run(lat, nsv, isum, mrun, 1'b0);
    check("t2_err", o_err, 32'd3);
    check("t2_first_fail", o_ff, 32'd1);
    check("t2_pass", 32'(o_pass), 32'd0);
    check("t2_samples", 32'(nsv), 32'd4);
    check("t2_idx_sum", 32'(isum), 32'd6);

    // Restart from DONE clears the scoreboard; re-pulses while busy are ignored
    stuck0 = 1'b0;
    run(lat, nsv, isum, mrun, 1'b1);
    check("t4_latency", 32'(lat), 32'd17);
    check("t4_err", o_err, 32'd0);
    check("t4_pass", 32'(o_pass), 32'd1);

    // Reset in the middle of a failing run
    stuck0 = 1'b1;
    @(negedge clk);
    #1 start = 1'b1;
    @(negedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 40 && o_vec != 32'd2; i++) @(negedge clk);
    check("t3_reached_vec2", o_vec, 32'd2);
    check("t3_err_before", o_err, 32'd1);
    #1 reset = 1'b1;
    @(negedge clk);
    check("t3_busy", 32'(o_busy), 32'd0);
    check("t3_in_vec", o_vec, 32'd0);
    check("t3_err", o_err, 32'd0);
    check("t3_done", 32'(o_done), 32'd0);
    #1 reset = 1'b0;
    stuck0 = 1'b0;
    run(lat, nsv, isum, mrun, 1'b0);
    check("t3_rerun_latency", 32'(lat), 32'd17);
    check("t3_rerun_pass", 32'(o_pass), 32'd1);

    // Randomized fault masks with random start re-pulses
    for (int r = 0; r < 6; r++) begin
      fm   = 4'($urandom_range(0, 15));
      flip = {12'd0, fm};
      run(lat, nsv, isum, mrun, 1'b1);
      lowest = 0;
      for (int j = 3; j >= 0; j--) if (fm[j]) lowest = j;
      check("rand_latency", 32'(lat), 32'd17);
      check("rand_err", o_err, 32'($countones(fm)));
      check("rand_first_fail", o_ff, 32'(lowest));
    end
    flip = '0;

    // Single-cycle hold, NAND gate
    switch_inst(1);
    run(lat, nsv, isum, mrun, 1'b0);
    check("t5_latency", 32'(lat), 32'd5);
    check("t5_samples", 32'(nsv), 32'd4);
    check("t5_consecutive", 32'(mrun), 32'd4);
    check("t5_pass", 32'(o_pass), 32'd1);

    // Three-input OR gate
    switch_inst(2);
    run(lat, nsv, isum, mrun, 1'b0);
    check("t6_latency", 32'(lat), 32'd33);
    check("t6_samples", 32'(nsv), 32'd8);
    check("t6_pass", 32'(o_pass), 32'd1);
    flip = 16'h0020;
    run(lat, nsv, isum, mrun, 1'b0);
    check("t6_err", o_err, 32'd1);
    check("t6_first_fail", o_ff, 32'd5);
    check("t6_fail_pass", 32'(o_pass), 32'd0);
    flip  = '0;
    x_en  = 1'b1;
    x_idx = 4'd5;
    run(lat, nsv, isum, mrun, 1'b0);
    x_en = 1'b0;
    for (int r = 0; r < 3; r++) begin
      flip = 16'($urandom_range(0, 255));
      run(lat, nsv, isum, mrun, 1'b1);
      check("rand3_err", o_err, 32'($countones(flip)));
    end
    flip = '0;

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
